// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// MemAccessUnit (top module mem_access_unit)
//
// Purpose:
//   Multi-cycle load/store sequencer sitting between the CPU memory stage and
//   the data memory. A request is checked for alignment, then turned into a
//   word-aligned bus access with big-endian byte enables. The pipeline is
//   held in stall until memory acknowledges or the access times out. Loads
//   capture the raw memory word and hand it to the read-data decoder
//   together with the registered offset/size/extension controls.
//
// Parameters:
//   TIMEOUT      maximum ACCESS cycles without memReady before busError (1..255)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   memRead      load request, held until stall drops
//   memWrite     store request, held until stall drops; wins over memRead
//   dataSize     00 word, 01 half, 10 byte, 11 illegal
//   bitExt       1 = zero-extend, 0 = sign-extend (passed to decoder)
//   physAddr     byte address of the access
//   wrData       right-justified store data
//   memRData     read word from memory
//   memReady     one-cycle memory acknowledge
//   stall        freeze the pipeline
//   memEnable    bus access in progress
//   memAddr      registered word-aligned address
//   memWe        byte enables, bit 3 drives bits 31:24
//   memWData     lane-replicated store data
//   rdData       captured read word for the decoder
//   decOffset    registered byte offset
//   decDataSize  registered access size
//   decBitExt    registered extension control
//   rdValid      one-cycle pulse, rdData is fresh
//   misaligned   one-cycle alignment fault pulse
//   busError     one-cycle timeout pulse
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  dataSize,
    input  logic        bitExt,
    input  logic [31:0] physAddr,
    input  logic [31:0] wrData,
    input  logic [31:0] memRData,
    input  logic        memReady,
    output logic        stall,
    output logic        memEnable,
    output logic [31:0] memAddr,
    output logic [3:0]  memWe,
    output logic [31:0] memWData,
    output logic [31:0] rdData,
    output logic [1:0]  decOffset,
    output logic [1:0]  decDataSize,
    output logic        decBitExt,
    output logic        rdValid,
    output logic        misaligned,
    output logic        busError
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } stateType;

    localparam logic [7:0] TimeoutCount = 8'(TIMEOUT);

    stateType    state;
    logic [7:0]  count;
    logic        accessIsStore;
    logic        request;
    logic        requestMisaligned;
    logic [3:0]  laneWe;
    logic [31:0] laneData;

    // A request is any load or store strobe. Alignment is judged against the
    // natural size of the access; the reserved size code is always a fault.
    always_comb begin
        request           = memRead | memWrite;
        requestMisaligned = 1'b0;
        case (dataSize)
            2'b00:   requestMisaligned = (physAddr[1:0] != 2'b00);
            2'b01:   requestMisaligned = physAddr[0];
            2'b10:   requestMisaligned = 1'b0;
            default: requestMisaligned = 1'b1;
        endcase
    end

    // Store lane steering. Memory is big-endian, so byte offset 0 lives in
    // bits 31:24 and the enable walks down from bit 3 as the offset grows.
    // Data is replicated into every lane so the enables alone pick the bytes.
    always_comb begin
        laneWe   = 4'b0000;
        laneData = wrData;
        case (dataSize)
            2'b00: begin
                laneWe   = 4'b1111;
                laneData = wrData;
            end
            2'b01: begin
                laneWe   = physAddr[1] ? 4'b0011 : 4'b1100;
                laneData = {2{wrData[15:0]}};
            end
            2'b10: begin
                laneWe   = 4'b1000 >> physAddr[1:0];
                laneData = {4{wrData[7:0]}};
            end
            default: begin
                laneWe   = 4'b0000;
                laneData = wrData;
            end
        endcase
    end

    // Stall must rise in the very cycle the request shows up, before any
    // register has seen it, so it is decoded straight from state and inputs.
    // The DONE cycle deliberately releases the pipeline.
    assign stall = ((state == IDLE) && request) || (state == ACCESS);

    // Sequencer. All bus-facing and decoder-facing outputs are registered
    // here; the fault and valid pulses are set on the transition into DONE
    // so they appear for exactly that one cycle. A memReady in the final
    // counted cycle is taken as success because it is checked before the
    // timeout comparison.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= 8'd0;
            accessIsStore <= 1'b0;
            memEnable     <= 1'b0;
            memAddr       <= 32'd0;
            memWe         <= 4'b0000;
            memWData      <= 32'd0;
            rdData        <= 32'd0;
            decOffset     <= 2'b00;
            decDataSize   <= 2'b00;
            decBitExt     <= 1'b0;
            rdValid       <= 1'b0;
            misaligned    <= 1'b0;
            busError      <= 1'b0;
        end else begin
            rdValid    <= 1'b0;
            misaligned <= 1'b0;
            busError   <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        memAddr       <= {physAddr[31:2], 2'b00};
                        decOffset     <= physAddr[1:0];
                        decDataSize   <= dataSize;
                        decBitExt     <= bitExt;
                        memWData      <= laneData;
                        accessIsStore <= memWrite;
                        count         <= 8'd0;
                        if (requestMisaligned) begin
                            state      <= DONE;
                            misaligned <= 1'b1;
                        end else begin
                            state     <= ACCESS;
                            memEnable <= 1'b1;
                            memWe     <= memWrite ? laneWe : 4'b0000;
                        end
                    end
                end
                ACCESS: begin
                    count <= count + 8'd1;
                    if (memReady) begin
                        state     <= DONE;
                        memEnable <= 1'b0;
                        memWe     <= 4'b0000;
                        if (!accessIsStore) begin
                            rdData  <= memRData;
                            rdValid <= 1'b1;
                        end
                    end else if ((count + 8'd1) == TimeoutCount) begin
                        state     <= DONE;
                        memEnable <= 1'b0;
                        memWe     <= 4'b0000;
                        rdData    <= 32'd0;
                        busError  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
